// File: rtl/ap_mem_pkg.sv
// ============================================================================
// Module : ap_mem_pkg
// Brief  : Shared types and helpers for the AP vector-memory scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ap_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sw_state_e;

  // Bit positions of each requester inside the arbiter req/gnt vectors
  localparam int GNT_A = 0;
  localparam int GNT_B = 1;

  function automatic int row_width(input int elem_w, input int num_units);
    return elem_w * num_units;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ap_rr_arb2.sv
// ============================================================================
// Module : ap_rr_arb2
// Brief  : Two-way round-robin arbiter with a last-grant flop; A wins first tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ap_rr_arb2
  import ap_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_b;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_req[GNT_A] && i_req[GNT_B]) begin
      if (r_last_b) w_gnt[GNT_A] = 1'b1;
      else          w_gnt[GNT_B] = 1'b1;
    end else if (i_req[GNT_A]) begin
      w_gnt[GNT_A] = 1'b1;
    end else if (i_req[GNT_B]) begin
      w_gnt[GNT_B] = 1'b1;
    end
  end

  assign o_gnt = w_gnt;

  // The rotation pointer only moves when both sides contend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (i_req[GNT_A] && i_req[GNT_B]) begin
      r_last_b <= w_gnt[GNT_B];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ap_mem_scheduler.sv
// ============================================================================
// Module : ap_mem_scheduler
// Brief  : Shares the AP memory write port between two requesters and streams
//          contiguous row sweeps out of its combinational read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ap_mem_scheduler
  import ap_mem_pkg::*;
#(
  parameter int ELEM_W     = 32,
  parameter int NUM_UNITS  = 8,
  parameter int MEM_HEIGHT = 1000,
  parameter int ADDR_W     = $clog2(MEM_HEIGHT) + 1,
  parameter int ROW_W      = row_width(ELEM_W, NUM_UNITS)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_a_req,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ROW_W-1:0]  i_a_data,
  output logic              o_a_ack,
  input  logic              i_b_req,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [ROW_W-1:0]  i_b_data,
  output logic              o_b_ack,
  output logic              o_wr_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [ROW_W-1:0]  o_mem_wdata,
  input  logic              i_sw_start,
  input  logic [ADDR_W-1:0] i_sw_base,
  input  logic [ADDR_W-1:0] i_sw_count,
  output logic [ADDR_W-1:0] o_mem_raddr,
  input  logic [ROW_W-1:0]  i_mem_rdata,
  output logic              o_rd_valid,
  output logic [ROW_W-1:0]  o_rd_data,
  output logic              o_sw_busy,
  output logic              o_sw_done
);

  localparam logic [ADDR_W-1:0] c_TOP_ROW = ADDR_W'(MEM_HEIGHT);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_oor;
  logic [ADDR_W-1:0] w_waddr;
  logic [ROW_W-1:0]  w_wdata;

  assign w_req[GNT_A] = i_a_req;
  assign w_req[GNT_B] = i_b_req;

  ap_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_any   = |w_gnt;
  assign w_waddr = w_gnt[GNT_B] ? i_b_addr : i_a_addr;
  assign w_wdata = w_gnt[GNT_B] ? i_b_data : i_a_data;
  assign w_oor   = (w_waddr > c_TOP_ROW);

  // Out-of-range grants are acked and flagged but never reach the memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_a_ack     <= 1'b0;
      o_b_ack     <= 1'b0;
      o_wr_err    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_waddr <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_a_ack  <= w_gnt[GNT_A];
      o_b_ack  <= w_gnt[GNT_B];
      o_wr_err <= w_any & w_oor;
      o_mem_we <= w_any & ~w_oor;
      if (w_any && !w_oor) begin
        o_mem_waddr <= w_waddr;
        o_mem_wdata <= w_wdata;
      end
    end
  end

  sw_state_e         r_state;
  sw_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_remain;
  logic [ADDR_W-1:0] w_raddr_inc;
  logic              w_load;
  logic              w_step;
  logic              w_done_nxt;

  assign w_raddr_inc = (o_mem_raddr == c_TOP_ROW) ? '0 : o_mem_raddr + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_sw_start) begin
          if (i_sw_count == '0) begin
            w_state_nxt = FIN;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_remain == ADDR_W'(1)) w_state_nxt = FIN;
      end
      FIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remain    <= '0;
      o_mem_raddr <= '0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      o_sw_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      o_rd_valid <= w_step;
      o_sw_done  <= w_done_nxt;
      if (w_load) begin
        o_mem_raddr <= i_sw_base;
        r_remain    <= i_sw_count;
      end
      if (w_step) begin
        o_rd_data   <= i_mem_rdata;
        o_mem_raddr <= w_raddr_inc;
        r_remain    <= r_remain - 1'b1;
      end
    end
  end

  assign o_sw_busy = (r_state != IDLE);

endmodule

`default_nettype wire
